uart_trx: RTL and testbench
===========================

Name: uart_trx

Overview:
- Full-duplex asynchronous serial transceiver (UART): independent transmit and receive paths sharing one clock and one reset.
- Frame format is set at elaboration time: start bit, data bits LSB first, optional parity bit, stop bits.
- Sits between a parallel byte interface in the system core and an external serial line.
- Bit timing is a fixed number of clock cycles per bit; there is no external baud tick.

Parameters:
- data_width_g, 8: number of data bits per frame, 5..9.
- parity_g, 2: parity mode. 0 = none, 1 = odd, 2 = even.
- stop_bits_g, 1: number of stop bits, 1 or 2.
- num_ticks_g, 16: clock cycles per serial bit, even, >= 4.

Ports:
- clk_i  in  1  system clock; all logic on rising edge.
- rst_asy_n_i  in  1  asynchronous active-low reset.
- rst_syn_i  in  1  synchronous active-high reset; same effect as rst_asy_n_i.
- data_i  in  data_width_g  TX parallel data.
- data_en_i  in  1  TX start strobe, one cycle.
- busy_o  out  1  TX frame in progress.
- done_o  out  1  TX frame complete, one-cycle pulse.
- tx_o  out  1  serial output, idle high.
- rx_i  in  1  serial input, asynchronous.
- rx_data_o  out  data_width_g  last received word.
- rx_en_o  out  1  rx_data_o valid, one-cycle pulse.
- rx_error_o  out  1  parity or framing error, one-cycle pulse.

Behaviour:
- Reset (either reset input) puts both state machines in IDLE and sets:
  - tx_o = 1, busy_o = 0, done_o = 0.
  - rx_data_o = 0, rx_en_o = 0, rx_error_o = 0.
- TX state machine: IDLE -> START -> DATA -> PARITY (skipped if parity_g = 0) -> STOP -> IDLE.
  - In IDLE, data_en_i = 1 latches data_i; busy_o rises the next cycle.
  - Every bit, including each stop bit, lasts exactly num_ticks_g cycles.
  - Data bits are sent LSB first.
  - Parity bit = XOR of the data bits for even parity; its inverse for odd parity.
  - At the last cycle of the final stop bit, the state returns to IDLE, busy_o falls and done_o pulses in the same cycle.
  - A new data_en_i is accepted in the cycle after done_o.
  - data_en_i while busy_o = 1 is ignored. The latched word is unaffected by later changes on data_i.
- RX input conditioning: rx_i passes through a 2-flop synchronizer before any use.
- RX state machine: IDLE -> START -> DATA -> PARITY (if enabled) -> STOP -> IDLE.
  - IDLE: a falling edge on the synchronized input starts START.
  - START: samples at num_ticks_g/2 cycles. If the line is high, the start is false; return to IDLE with no output.
  - Each following bit is sampled once, num_ticks_g cycles after the previous sample (mid-bit).
  - Data bits are shifted in LSB first.
  - At the sample of the last stop bit:
    - Stop bit(s) = 1 and parity OK: rx_data_o updates and rx_en_o pulses for one cycle.
    - Otherwise: rx_error_o pulses for one cycle, rx_en_o stays 0, rx_data_o keeps its old value.
  - After that sample, return to IDLE immediately; the next falling edge is detected from there.
- The TX and RX paths are fully independent; simultaneous activity is allowed.
- Reset asserted mid-frame aborts the frame immediately: tx_o returns high and no rx_en_o or done_o pulse is produced.
- Default timing: frame = 11 bits × 16 cycles = 176 cycles.
  - RX pulse occurs about 2 (synchronizer) + 168 cycles after the start-bit falling edge on rx_i.

Optional Feature:
- Macro UART_TRX_LOOPBACK_EN.
- Defined: adds input port loopback_i (1 bit).
  - loopback_i = 1: the RX path takes the internal TX serial signal instead of rx_i, and tx_o is held at 1.
  - loopback_i = 0: normal operation.
- Not defined: no loopback_i port; RX always uses rx_i.

Test Plan:
- Default parameters, tx_o wired externally to rx_i, reset held for 42 ns, clock period 25 ns. Send 0xAA, wait for busy_o to fall, wait 200 ns:
  - tx_o shows start 0, bits 0,1,0,1,0,1,0,1, parity 0, stop 1, each 16 cycles.
  - rx_en_o pulses with rx_data_o = 0xAA; rx_error_o = 0.
- Send 0xCC, 0x55, 0x33 back to back, each after done_o plus 200 ns:
  - rx_data_o reads 0xCC, 0x55, 0x33 in order, exactly one rx_en_o per frame.
  - busy_o high for exactly 176 cycles per frame.
- Pulse data_en_i with 0x12 while busy_o = 1 during a 0xAA frame: only 0xAA is transmitted and received.
- Drive rx_i with a 0x55 frame whose parity bit is wrong: rx_error_o pulses, no rx_en_o, rx_data_o unchanged.
- Drive rx_i with a 0xAA frame whose stop bit is 0, then a 4-cycle low glitch:
  - The bad stop bit gives a single rx_error_o pulse.
  - The glitch gives no output and RX returns to IDLE.
- Assert rst_asy_n_i low mid-frame: tx_o = 1 and busy_o = 0 immediately, no done_o. A later 0xAA transfer completes correctly.

Source files
------------

// File: rtl/uart_trx.sv
// uart_trx: full-duplex UART transceiver with elaboration-time frame format.
// Each bit lasts num_ticks_g clock cycles. There is no external baud tick.
// Both paths reset from either rst_asy_n_i (asynchronous, active low) or
// rst_syn_i (synchronous, active high), and the two have the same effect.
// Optional feature: define UART_TRX_LOOPBACK_EN to add loopback_i, which
// routes the internal TX line into RX and holds tx_o high.
//
// TX / RX state table (shared encoding)
//   state    | meaning
//   S_IDLE   | line idle; TX waits for data_en_i, RX waits for a falling edge
//   S_START  | start bit (TX drives 0; RX confirms low at mid-bit)
//   S_DATA   | data bits, LSB first
//   S_PARITY | parity bit (never entered when parity_g = 0)
//   S_STOP   | stop bit(s); the last one ends the frame
`timescale 1ns/1ps
module uart_trx #(
    parameter int data_width_g = 8,
    parameter int parity_g     = 2,
    parameter int stop_bits_g  = 1,
    parameter int num_ticks_g  = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_asy_n_i,
    input  logic                    rst_syn_i,
`ifdef UART_TRX_LOOPBACK_EN
    input  logic                    loopback_i,
`endif
    input  logic [data_width_g-1:0] data_i,
    input  logic                    data_en_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    tx_o,
    input  logic                    rx_i,
    output logic [data_width_g-1:0] rx_data_o,
    output logic                    rx_en_o,
    output logic                    rx_error_o
);

    localparam int TICK_W = $clog2(num_ticks_g);
    localparam int BIT_W  = $clog2(data_width_g);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(num_ticks_g - 1);
    localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(num_ticks_g / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(data_width_g - 1);
    localparam logic              STOP_LAST = 1'(stop_bits_g - 1);
    localparam logic              PAR_EN    = (parity_g != 0);
    // Seed for the running XOR so the result is directly the expected parity bit.
    localparam logic              PAR_ODD   = (parity_g == 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    // ------------------------------------------------------------------
    // Transmit path
    // ------------------------------------------------------------------
    logic [2:0]              tx_state;
    logic [TICK_W-1:0]       tx_tick;
    logic [BIT_W-1:0]        tx_bit;
    logic                    tx_stop;
    logic [data_width_g-1:0] tx_shift;
    logic                    tx_par;
    logic                    tx_line;

    // TX frame sequencer: bit timer counts down, terminal count advances the bit.
    always_ff @(posedge clk_i or negedge rst_asy_n_i) begin
        if (!rst_asy_n_i) begin
            tx_state <= S_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else if (rst_syn_i) begin
            tx_state <= S_IDLE;
            tx_tick  <= '0;
            tx_bit   <= '0;
            tx_stop  <= 1'b0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            tx_line  <= 1'b1;
            busy_o   <= 1'b0;
            done_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (tx_state == S_IDLE) begin
                if (data_en_i) begin
                    tx_shift <= data_i;
                    tx_par   <= (^data_i) ^ PAR_ODD;
                    tx_tick  <= TICK_LAST;
                    tx_line  <= 1'b0;
                    busy_o   <= 1'b1;
                    tx_state <= S_START;
                end
            end else if (tx_tick != '0) begin
                tx_tick <= tx_tick - 1'b1;
            end else begin
                tx_tick <= TICK_LAST;
                case (tx_state)
                    S_START: begin
                        tx_state <= S_DATA;
                        tx_line  <= tx_shift[0];
                        tx_bit   <= BIT_LAST;
                    end
                    S_DATA: begin
                        if (tx_bit != '0) begin
                            tx_bit   <= tx_bit - 1'b1;
                            tx_shift <= tx_shift >> 1;
                            tx_line  <= tx_shift[1];
                        end else if (PAR_EN) begin
                            tx_state <= S_PARITY;
                            tx_line  <= tx_par;
                        end else begin
                            tx_state <= S_STOP;
                            tx_line  <= 1'b1;
                            tx_stop  <= STOP_LAST;
                        end
                    end
                    S_PARITY: begin
                        tx_state <= S_STOP;
                        tx_line  <= 1'b1;
                        tx_stop  <= STOP_LAST;
                    end
                    S_STOP: begin
                        if (tx_stop != 1'b0) begin
                            tx_stop <= 1'b0;
                        end else begin
                            // Last cycle of the final stop bit: busy falls, done pulses.
                            tx_state <= S_IDLE;
                            busy_o   <= 1'b0;
                            done_o   <= 1'b1;
                        end
                    end
                    default: begin
                        tx_state <= S_IDLE;
                        tx_line  <= 1'b1;
                        busy_o   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Line routing (loopback option)
    // ------------------------------------------------------------------
    logic rx_src;

`ifdef UART_TRX_LOOPBACK_EN
    assign tx_o   = loopback_i ? 1'b1 : tx_line;
    assign rx_src = loopback_i ? tx_line : rx_i;
`else
    assign tx_o   = tx_line;
    assign rx_src = rx_i;
`endif

    // ------------------------------------------------------------------
    // Receive path
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rx_sync;
    logic rx_prev;
    logic rx_fall;

    // Two-flop synchronizer plus one history flop for edge detection; idles high.
    always_ff @(posedge clk_i or negedge rst_asy_n_i) begin
        if (!rst_asy_n_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else if (rst_syn_i) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign rx_fall = rx_prev & ~rx_sync;

    logic [2:0]              rx_state;
    logic [TICK_W-1:0]       rx_tick;
    logic [BIT_W-1:0]        rx_bit;
    logic                    rx_stop;
    logic [data_width_g-1:0] rx_shift;
    logic                    rx_par;
    logic                    rx_bad;

    // RX frame sequencer: half-bit delay to the start sample, then one sample per bit.
    always_ff @(posedge clk_i or negedge rst_asy_n_i) begin
        if (!rst_asy_n_i) begin
            rx_state   <= S_IDLE;
            rx_tick    <= '0;
            rx_bit     <= '0;
            rx_stop    <= 1'b0;
            rx_shift   <= '0;
            rx_par     <= 1'b0;
            rx_bad     <= 1'b0;
            rx_data_o  <= '0;
            rx_en_o    <= 1'b0;
            rx_error_o <= 1'b0;
        end else if (rst_syn_i) begin
            rx_state   <= S_IDLE;
            rx_tick    <= '0;
            rx_bit     <= '0;
            rx_stop    <= 1'b0;
            rx_shift   <= '0;
            rx_par     <= 1'b0;
            rx_bad     <= 1'b0;
            rx_data_o  <= '0;
            rx_en_o    <= 1'b0;
            rx_error_o <= 1'b0;
        end else begin
            rx_en_o    <= 1'b0;
            rx_error_o <= 1'b0;
            if (rx_state == S_IDLE) begin
                if (rx_fall) begin
                    rx_state <= S_START;
                    rx_tick  <= TICK_HALF;
                end
            end else if (rx_tick != '0) begin
                rx_tick <= rx_tick - 1'b1;
            end else begin
                rx_tick <= TICK_LAST;
                case (rx_state)
                    S_START: begin
                        if (rx_sync) begin
                            // Line back high at mid start bit: glitch, not a frame.
                            rx_state <= S_IDLE;
                        end else begin
                            rx_state <= S_DATA;
                            rx_bit   <= BIT_LAST;
                            rx_par   <= PAR_ODD;
                            rx_bad   <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        rx_shift <= {rx_sync, rx_shift[data_width_g-1:1]};
                        rx_par   <= rx_par ^ rx_sync;
                        if (rx_bit != '0) begin
                            rx_bit <= rx_bit - 1'b1;
                        end else if (PAR_EN) begin
                            rx_state <= S_PARITY;
                        end else begin
                            rx_state <= S_STOP;
                            rx_stop  <= STOP_LAST;
                        end
                    end
                    S_PARITY: begin
                        rx_bad   <= (rx_sync != rx_par);
                        rx_state <= S_STOP;
                        rx_stop  <= STOP_LAST;
                    end
                    S_STOP: begin
                        if (rx_stop != 1'b0) begin
                            rx_bad  <= rx_bad | ~rx_sync;
                            rx_stop <= 1'b0;
                        end else begin
                            if (rx_bad || !rx_sync) begin
                                rx_error_o <= 1'b1;
                            end else begin
                                rx_data_o <= rx_shift;
                                rx_en_o   <= 1'b1;
                            end
                            rx_state <= S_IDLE;
                        end
                    end
                    default: begin
                        rx_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_trx.sv
// tb_uart_trx: directed bench for uart_trx with default parameters.
// Expected received words go into a scoreboard queue when a frame is sent
// and are popped by the rx_en_o monitor.
`timescale 1ns/1ps
module tb_uart_trx;

    logic       clk       = 1'b0;
    logic       rst_asy_n = 1'b0;
    logic       rst_syn   = 1'b0;
    logic [7:0] data      = 8'h00;
    logic       data_en   = 1'b0;
    logic       use_ext   = 1'b0;
    logic       rx_drv    = 1'b1;
    logic       busy, done, tx, rx_en, rx_err, rx_line;
    logic [7:0] rx_data;

    int n_checks   = 0;
    int n_fail     = 0;
    int rx_en_cnt  = 0;
    int rx_err_cnt = 0;
    logic [7:0] sb[$];
    logic [7:0] sb_exp;

    always #12.5 clk = ~clk;

    assign rx_line = use_ext ? rx_drv : tx;

    uart_trx dut (
        .clk_i      (clk),
        .rst_asy_n_i(rst_asy_n),
        .rst_syn_i  (rst_syn),
        .data_i     (data),
        .data_en_i  (data_en),
        .busy_o     (busy),
        .done_o     (done),
        .tx_o       (tx),
        .rx_i       (rx_line),
        .rx_data_o  (rx_data),
        .rx_en_o    (rx_en),
        .rx_error_o (rx_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every rx_en_o pulse must match the oldest queued word.
    always @(negedge clk) begin
        if (rx_en) begin
            rx_en_cnt++;
            chk("rx_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                sb_exp = sb.pop_front();
                chk("rx_data", 32'(rx_data), 32'(sb_exp));
            end
        end
        if (rx_err) rx_err_cnt++;
    end

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        data    = v;
        data_en = 1'b1;
        @(negedge clk);
        data_en = 1'b0;
    endtask

    // One looped-back frame: checks tx bit values, busy length, done timing, RX result.
    task automatic tx_frame(input logic [7:0] v, input bit ignore_test);
        logic [10:0] eb;
        int cyc, busy_cnt, done_cyc, e0, r0;
        eb       = {1'b1, ^v, v, 1'b0};
        busy_cnt = 0;
        done_cyc = 0;
        e0       = rx_en_cnt;
        r0       = rx_err_cnt;
        sb.push_back(v);
        send(v);
        cyc = 1;
        while (done_cyc == 0 && cyc < 400) begin
            if (busy) busy_cnt++;
            if (done) done_cyc = cyc;
            if ((cyc % 16) == 8 && cyc < 176)
                chk($sformatf("tx_bit%0d_%0h", cyc / 16, v), 32'(tx), 32'(eb[cyc / 16]));
            if (ignore_test && cyc == 50) begin
                data    = 8'h12;
                data_en = 1'b1;
            end
            if (ignore_test && cyc == 51) data_en = 1'b0;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("busy_cycles_%0h", v), 32'(busy_cnt), 32'd176);
        chk($sformatf("done_cycle_%0h", v), 32'(done_cyc), 32'd177);
        repeat (8) @(negedge clk);
        chk($sformatf("sb_empty_%0h", v), 32'(sb.size()), 32'd0);
        chk($sformatf("rx_en_count_%0h", v), 32'(rx_en_cnt - e0), 32'd1);
        chk($sformatf("rx_err_count_%0h", v), 32'(rx_err_cnt - r0), 32'd0);
        chk($sformatf("busy_idle_%0h", v), 32'(busy), 32'd0);
    endtask

    // Drive one 11-bit frame on rx_i, bit 0 first, 16 cycles per bit.
    task automatic drive_rx(input logic [10:0] bits);
        for (int i = 0; i < 11; i++) begin
            rx_drv = bits[i];
            repeat (16) @(negedge clk);
        end
        rx_drv = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    // Watch a quiet period: no done_o, no RX output of any kind.
    task automatic quiet(input string tag, input int n);
        int d, e0, r0;
        d  = 0;
        e0 = rx_en_cnt;
        r0 = rx_err_cnt;
        for (int i = 0; i < n; i++) begin
            if (done) d++;
            @(negedge clk);
        end
        chk({tag, "_no_done"}, 32'(d), 32'd0);
        chk({tag, "_no_rx_en"}, 32'(rx_en_cnt - e0), 32'd0);
        chk({tag, "_no_rx_err"}, 32'(rx_err_cnt - r0), 32'd0);
    endtask

    initial begin
        int e0, r0;
        #42 rst_asy_n = 1'b1;
        @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_rx_en", 32'(rx_en), 32'd0);
        chk("rst_rx_err", 32'(rx_err), 32'd0);

        tx_frame(8'hAA, 1'b0);
        tx_frame(8'hCC, 1'b0);
        tx_frame(8'h55, 1'b0);
        tx_frame(8'h33, 1'b0);
        // data_en_i with 0x12 mid-frame must be ignored
        tx_frame(8'hAA, 1'b1);
        chk("ignored_no_restart", 32'(busy), 32'd0);

        // Externally driven frames
        use_ext = 1'b1;
        e0 = rx_en_cnt;
        r0 = rx_err_cnt;
        drive_rx({1'b1, 1'b1, 8'h55, 1'b0});
        chk("par_err_pulse", 32'(rx_err_cnt - r0), 32'd1);
        chk("par_err_no_en", 32'(rx_en_cnt - e0), 32'd0);
        chk("par_err_data_kept", 32'(rx_data), 32'h0AA);

        e0 = rx_en_cnt;
        r0 = rx_err_cnt;
        drive_rx({1'b0, 1'b0, 8'hAA, 1'b0});
        chk("stop_err_pulse", 32'(rx_err_cnt - r0), 32'd1);
        chk("stop_err_no_en", 32'(rx_en_cnt - e0), 32'd0);

        rx_drv = 1'b0;
        repeat (4) @(negedge clk);
        rx_drv = 1'b1;
        quiet("glitch", 40);

        e0 = rx_en_cnt;
        sb.push_back(8'h3C);
        drive_rx({1'b1, 1'b0, 8'h3C, 1'b0});
        chk("ext_frame_en", 32'(rx_en_cnt - e0), 32'd1);
        chk("ext_frame_sb_empty", 32'(sb.size()), 32'd0);
        use_ext = 1'b0;

        // Asynchronous reset mid-frame
        send(8'h5A);
        repeat (60) @(negedge clk);
        rst_asy_n = 1'b0;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_asy_n = 1'b1;
        quiet("arst", 300);

        // Synchronous reset mid-frame
        send(8'h0F);
        repeat (30) @(negedge clk);
        rst_syn = 1'b1;
        @(negedge clk);
        chk("srst_tx", 32'(tx), 32'd1);
        chk("srst_busy", 32'(busy), 32'd0);
        rst_syn = 1'b0;
        quiet("srst", 300);

        tx_frame(8'hAA, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
